cam_avg_ctrl: RTL and testbench

Frame-windowed, multi-channel camera average scheduler for the VGA capture path. It turns frame-boundary pulses into accumulate windows and counts frames. Every FRAME_DIV frames it snapshots per-channel pixel sums and sequences one shared sequential divider across all channels in fixed order. The per-channel averages are published together as the display/processing color.

---
 rtl/cam_avg_pkg.sv | 15 +
 rtl/cam_avg_div.sv | 100 ++++++++++
 rtl/cam_avg_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cam_avg_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cam_avg_pkg.sv
// Shared types and constants for the camera average scheduler.
package cam_avg_pkg;

    localparam int         PIX_W   = 8;
    localparam logic [7:0] PIX_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DIV     = 3'd2,
        STORE   = 3'd3,
        PUBLISH = 3'd4
    } cam_avg_state_t;

endpackage

// File: rtl/cam_avg_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first step is taken on the start edge itself, so the quotient is
// complete and done is high during the ACC_W-th cycle after start.
module cam_avg_div #(
    parameter int ACC_W = 32
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [ACC_W-1:0] divisor,
    output logic [ACC_W-1:0] quotient,
    output logic             done
);

    localparam int             CW        = $clog2(ACC_W) + 1;
    localparam logic [CW-1:0]  STEP_ONE  = CW'(1);
    localparam logic [CW-1:0]  STEP_LAST = CW'(ACC_W - 1);

    // One restoring step: returns {remainder, shifted quotient}.
    function automatic logic [2*ACC_W-1:0] div_step(
        input logic [ACC_W-1:0] rem,
        input logic [ACC_W-1:0] q,
        input logic [ACC_W-1:0] d
    );
        logic [ACC_W:0] trial;
        logic           bit_s;
        trial = {rem, q[ACC_W-1]};
        if (trial >= {1'b0, d}) begin
            trial = trial - {1'b0, d};
            bit_s = 1'b1;
        end else begin
            bit_s = 1'b0;
        end
        return {trial[ACC_W-1:0], q[ACC_W-2:0], bit_s};
    endfunction

    logic [ACC_W-1:0]   rem_r;
    logic [ACC_W-1:0]   quo_r;
    logic [ACC_W-1:0]   dvs_r;
    logic [CW-1:0]      step_r;
    logic               run_r;
    logic               done_r;
    logic [ACC_W-1:0]   rem_in_s;
    logic [ACC_W-1:0]   quo_in_s;
    logic [ACC_W-1:0]   dvs_in_s;
    logic [2*ACC_W-1:0] step_s;

    // Select fresh operands on start, otherwise continue the running division.
    always_comb begin
        rem_in_s = '0;
        quo_in_s = quo_r;
        dvs_in_s = dvs_r;
        if (start) begin
            rem_in_s = '0;
            quo_in_s = dividend;
            dvs_in_s = divisor;
        end else begin
            rem_in_s = rem_r;
            quo_in_s = quo_r;
            dvs_in_s = dvs_r;
        end
        step_s = div_step(rem_in_s, quo_in_s, dvs_in_s);
    end

    // Iteration registers, step counter and done pulse.
    always_ff @(posedge VGA_CLK or negedge RST) begin
        if (!RST) begin
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            step_r <= '0;
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= step_s[2*ACC_W-1:ACC_W];
            quo_r  <= step_s[ACC_W-1:0];
            dvs_r  <= divisor;
            step_r <= STEP_ONE;
            run_r  <= (ACC_W > 1);
            done_r <= (ACC_W == 1);
        end else if (run_r) begin
            rem_r  <= step_s[2*ACC_W-1:ACC_W];
            quo_r  <= step_s[ACC_W-1:0];
            step_r <= step_r + STEP_ONE;
            if (step_r == STEP_LAST) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = quo_r;
    assign done     = done_r;

endmodule

// File: rtl/cam_avg_ctrl.sv
// Frame-windowed multi-channel average scheduler: accumulates pixel sums per
// frame, and every FRAME_DIV frames divides each channel sum by the pixel
// count through one shared divider, publishing all averages together.
module cam_avg_ctrl
    import cam_avg_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int FRAME_DIV = 30,
    parameter int ACC_W     = 32
) (
    input  logic                  VGA_CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  pix_valid,
    input  logic [N_CH*PIX_W-1:0] pixel,
    output logic [N_CH*PIX_W-1:0] color,
    output logic                  color_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int               FW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0]    FCNT_LAST = FW'(FRAME_DIV - 1);
    localparam int               CHW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CHW-1:0]   CH_LAST   = CHW'(N_CH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ONE   = ACC_W'(1);

    // Saturating add of one pixel into a channel sum.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [PIX_W-1:0] p);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W+1-PIX_W){1'b0}}, p};
        return sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
    endfunction

    // Clamp a quotient to the pixel range.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic [ACC_W-1:0] q);
        return (q > ACC_W'(PIX_MAX)) ? PIX_MAX : q[PIX_W-1:0];
    endfunction

    logic [ACC_W-1:0]     acc_r      [N_CH];
    logic [ACC_W-1:0]     snap_r     [N_CH];
    logic [PIX_W-1:0]     stage_r    [N_CH];
    logic [ACC_W-1:0]     cnt_r;
    logic [ACC_W-1:0]     snap_cnt_r;
    logic [FW-1:0]        fcnt_r;
    logic [CHW-1:0]       ch_r;
    cam_avg_state_t       state_r;
    cam_avg_state_t       state_s;
    logic [N_CH*PIX_W-1:0] color_r;
    logic                 color_valid_r;
    logic                 overrun_r;
    logic                 trigger_s;
    logic                 idle_s;
    logic                 div_start_s;
    logic [ACC_W-1:0]     div_quo_s;
    logic                 div_done_s;

    assign trigger_s = frame_end && (fcnt_r == FCNT_LAST);
    assign idle_s    = (state_r == IDLE);

    // Per-frame channel sums and pixel count; frame_start restarts them.
    always_ff @(posedge VGA_CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < N_CH; k++) acc_r[k] <= '0;
            cnt_r <= '0;
        end else if (frame_start) begin
            for (int k = 0; k < N_CH; k++)
                acc_r[k] <= pix_valid ? {{(ACC_W-PIX_W){1'b0}}, pixel[k*PIX_W +: PIX_W]} : '0;
            cnt_r <= pix_valid ? ACC_ONE : '0;
        end else if (pix_valid && !frame_end) begin
            for (int k = 0; k < N_CH; k++)
                acc_r[k] <= sat_add(acc_r[k], pixel[k*PIX_W +: PIX_W]);
            if (cnt_r != ACC_MAX) cnt_r <= cnt_r + ACC_ONE;
        end
    end

    // Frame counter, epoch snapshot and overrun flag.
    always_ff @(posedge VGA_CLK or negedge RST) begin
        if (!RST) begin
            fcnt_r     <= '0;
            snap_cnt_r <= '0;
            overrun_r  <= 1'b0;
            for (int k = 0; k < N_CH; k++) snap_r[k] <= '0;
        end else begin
            overrun_r <= trigger_s && !idle_s;
            if (frame_end) fcnt_r <= trigger_s ? '0 : fcnt_r + FW'(1);
            if (trigger_s && idle_s) begin
                for (int k = 0; k < N_CH; k++) snap_r[k] <= acc_r[k];
                snap_cnt_r <= cnt_r;
            end
        end
    end

    // Next-state logic for the divide sequence.
    always_comb begin
        state_s     = state_r;
        div_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (trigger_s) state_s = LOAD;
                else           state_s = IDLE;
            end
            LOAD: begin
                if (snap_cnt_r == '0) begin
                    state_s = STORE;
                end else begin
                    state_s     = DIV;
                    div_start_s = 1'b1;
                end
            end
            DIV: begin
                if (div_done_s) state_s = STORE;
                else            state_s = DIV;
            end
            STORE: begin
                if (ch_r == CH_LAST) state_s = PUBLISH;
                else                 state_s = LOAD;
            end
            PUBLISH: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, channel index, staging and published outputs.
    always_ff @(posedge VGA_CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= IDLE;
            ch_r          <= '0;
            color_r       <= '0;
            color_valid_r <= 1'b0;
            for (int k = 0; k < N_CH; k++) stage_r[k] <= '0;
        end else begin
            state_r       <= state_s;
            color_valid_r <= (state_r == PUBLISH);
            if (idle_s && trigger_s) ch_r <= '0;
            if (state_r == STORE) begin
                stage_r[ch_r] <= (snap_cnt_r == '0) ? '0 : clamp_pix(div_quo_s);
                if (ch_r != CH_LAST) ch_r <= ch_r + CHW'(1);
            end
            if (state_r == PUBLISH) begin
                for (int k = 0; k < N_CH; k++) color_r[k*PIX_W +: PIX_W] <= stage_r[k];
            end
        end
    end

    cam_avg_div #(.ACC_W(ACC_W)) u_div (
        .VGA_CLK  (VGA_CLK),
        .RST      (RST),
        .start    (div_start_s),
        .dividend (snap_r[ch_r]),
        .divisor  (snap_cnt_r),
        .quotient (div_quo_s),
        .done     (div_done_s)
    );

    assign color       = color_r;
    assign color_valid = color_valid_r;
    assign overrun     = overrun_r;
    assign busy        = !idle_s;

endmodule

// File: tb/tb_cam_avg_ctrl.sv
// Directed bench for cam_avg_ctrl: one instance with FRAME_DIV=2 and one with
// FRAME_DIV=1, sharing clock, reset and stimulus.
module tb_cam_avg_ctrl;

    logic        VGA_CLK = 1'b0;
    logic        RST;
    logic        frame_start;
    logic        frame_end;
    logic        pix_valid;
    logic [23:0] pixel;
    logic [23:0] color1, color2;
    logic        cv1, cv2, busy1, busy2, ov1, ov2;

    int total = 0;
    int bad   = 0;
    int nv1   = 0;
    int nv2   = 0;
    int nov1  = 0;

    always #5 VGA_CLK = ~VGA_CLK;

    cam_avg_ctrl #(.N_CH(3), .FRAME_DIV(2), .ACC_W(32)) u_dut2 (
        .VGA_CLK(VGA_CLK), .RST(RST), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pixel(pixel), .color(color2), .color_valid(cv2),
        .busy(busy2), .overrun(ov2)
    );

    cam_avg_ctrl #(.N_CH(3), .FRAME_DIV(1), .ACC_W(32)) u_dut1 (
        .VGA_CLK(VGA_CLK), .RST(RST), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pixel(pixel), .color(color1), .color_valid(cv1),
        .busy(busy1), .overrun(ov1)
    );

    // Count output pulses, sampled away from the active edge.
    always @(negedge VGA_CLK) begin
        if (cv1) nv1++;
        if (cv2) nv2++;
        if (ov1) nov1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic pix(input logic [23:0] p);
        pix_valid = 1'b1;
        pixel     = p;
        cyc();
        pix_valid = 1'b0;
        pixel     = 24'h0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic fend();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
    endtask

    task automatic wait_cv(input int which, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            cyc();
            if ((which == 1 && cv1) || (which == 2 && cv2)) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int base_v;
    int base_o;
    logic [7:0] b;

    initial begin
        RST = 1'b0; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0; pixel = 24'h0;
        repeat (3) cyc();
        check("rst_color", 32'(color2), 32'h0);
        check("rst_cv", 32'(cv2), 32'h0);
        check("rst_busy", 32'(busy2), 32'h0);
        check("rst_ovr", 32'(ov2), 32'h0);
        RST = 1'b1;
        cyc();

        // Uniform frames on the two-frame epoch instance.
        fstart();
        repeat (100) pix(24'hFF800A);
        fend();
        base_v = nv2;
        repeat (10) cyc();
        check("uni_no_pulse_first", 32'(nv2 - base_v), 32'd0);
        check("uni_idle_first", 32'(busy2), 32'h0);
        fstart();
        repeat (100) pix(24'hFF800A);
        fend();
        check("uni_busy", 32'(busy2), 32'h1);
        wait_cv(2, 200, n);
        check("uni_latency", 32'(n), 32'd103);
        check("uni_color", 32'(color2), 32'h00FF800A);
        cyc();
        check("uni_cv_width", 32'(cv2), 32'h0);

        // Reset in the middle of a divide.
        fstart();
        repeat (5) pix(24'h323232);
        fend();
        fstart();
        repeat (5) pix(24'h323232);
        fend();
        repeat (10) cyc();
        check("mid_busy_pre", 32'(busy2), 32'h1);
        RST = 1'b0;
        #1;
        check("mid_busy", 32'(busy2), 32'h0);
        check("mid_color", 32'(color2), 32'h0);
        check("mid_cv", 32'(cv2), 32'h0);
        base_v = nv2;
        repeat (3) cyc();
        RST = 1'b1;
        repeat (120) cyc();
        check("mid_no_publish", 32'(nv2 - base_v), 32'd0);

        // Ramp 0..99 on the single-frame instance.
        fstart();
        for (int i = 0; i < 100; i++) begin
            b = 8'(i);
            pix({b, b, b});
        end
        fend();
        wait_cv(1, 200, n);
        check("ramp_latency", 32'(n), 32'd103);
        check("ramp_color", 32'(color1), 32'h00313131);

        // Empty frame: no pixels, divider skipped.
        cyc();
        fstart();
        fend();
        wait_cv(1, 50, n);
        check("empty_latency", 32'(n), 32'd7);
        check("empty_color", 32'(color1), 32'h0);

        // Second trigger 20 cycles after the first is dropped.
        fstart();
        repeat (10) pix(24'h141414);
        base_v = nv1;
        base_o = nov1;
        fend();
        repeat (19) cyc();
        fend();
        check("ovr_pulse", 32'(ov1), 32'h1);
        cyc();
        check("ovr_width", 32'(ov1), 32'h0);
        wait_cv(1, 200, n);
        check("ovr_latency", 32'(n), 32'd82);
        check("ovr_color", 32'(color1), 32'h00141414);
        repeat (150) cyc();
        check("ovr_one_publish", 32'(nv1 - base_v), 32'd1);
        check("ovr_one_pulse", 32'(nov1 - base_o), 32'd1);

        // Coincident frame_start/frame_end with a pixel.
        fstart();
        repeat (4) pix(24'h282828);
        frame_start = 1'b1; frame_end = 1'b1; pix_valid = 1'b1; pixel = 24'h070707;
        cyc();
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0; pixel = 24'h0;
        wait_cv(1, 200, n);
        check("coin_latency", 32'(n), 32'd103);
        check("coin_old_sum", 32'(color1), 32'h00282828);
        // New frame holds 7 from the restart; add 9, then a pixel on frame_end.
        pix(24'h090909);
        frame_end = 1'b1; pix_valid = 1'b1; pixel = 24'hC8C8C8;
        cyc();
        frame_end = 1'b0; pix_valid = 1'b0; pixel = 24'h0;
        wait_cv(1, 200, n);
        check("coin_restart_latency", 32'(n), 32'd103);
        check("coin_restart_color", 32'(color1), 32'h00080808);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
